// File: rtl/sum_loop_pkg.sv
// Shared types, widths and the loop-invariant helper for the summation-loop sequencer.
package sum_loop_pkg;

  localparam int unsigned SL_W  = 13;
  localparam int unsigned SL_CW = SL_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // True when !(2n >= k+j+i); evaluated two bits wider so neither side truncates.
  function automatic logic inv_check(input logic [SL_W-1:0] n,
                                     input logic [SL_W-1:0] k,
                                     input logic [SL_W-1:0] j,
                                     input logic [SL_W-1:0] i);
    logic [SL_CW-1:0] lhs;
    logic [SL_CW-1:0] rhs;
    lhs = SL_CW'(n) << 1;
    rhs = SL_CW'(k) + SL_CW'(j) + SL_CW'(i);
    return !(lhs >= rhs);
  endfunction

endpackage

// File: rtl/sum_loop_sched_rr_arb2.sv
// Two-input round-robin arbiter: combinational pick, registered last-served pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt_c,
  output logic       id_c,
  output logic       vld_c
);

  logic last_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    id_c = 1'b0;
    case (req)
      2'b01:   id_c = 1'b0;
      2'b10:   id_c = 1'b1;
      2'b11:   id_c = ~last_q;
      default: id_c = 1'b0;
    endcase
    vld_c = |req;
    gnt_c = {vld_c & id_c, vld_c & ~id_c};
  end

  // Reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= id_c;
    end
  end

endmodule

// File: rtl/sum_loop_sched.sv
// Shared sequencer: arbitrates two requesters and runs j += i, i++ until i > n.
import sum_loop_pkg::*;

module sum_loop_sched #(
  parameter int unsigned W = SL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] n_in0,
  input  logic [W-1:0] k_in0,
  input  logic [W-1:0] n_in1,
  input  logic [W-1:0] k_in1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic         err,
  output logic [W-1:0] j_out,
  output logic [W-1:0] i_out,
  output logic         inv_ok
);

  state_t state_q;
  state_t state_d;

  logic [W-1:0] n_q;
  logic [W-1:0] k_q;
  logic [W-1:0] i_q;
  logic [W-1:0] j_q;
  logic         id_q;

  logic [1:0]   arb_gnt_c;
  logic         arb_id_c;
  logic         arb_vld_c;
  logic [W-1:0] sel_n_c;
  logic [W-1:0] sel_k_c;
  logic         sel_ones_c;

  logic accept_c;
  logic reject_c;
  logic step_c;
  logic fin_c;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .upd   (accept_c | reject_c),
    .gnt_c (arb_gnt_c),
    .id_c  (arb_id_c),
    .vld_c (arb_vld_c)
  );

  // An all-ones bound can never be exceeded, so such a request is bounced.
  always_comb begin
    sel_n_c    = arb_id_c ? n_in1 : n_in0;
    sel_k_c    = arb_id_c ? k_in1 : k_in0;
    sel_ones_c = &sel_n_c;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The last iteration (i == n) and the move to FIN share one edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = RUN;
      RUN:     if (i_q >= n_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept_c = 1'b0;
    reject_c = 1'b0;
    step_c   = 1'b0;
    fin_c    = 1'b0;
    case (state_q)
      IDLE: begin
        accept_c = arb_vld_c & ~sel_ones_c;
        reject_c = arb_vld_c & sel_ones_c;
      end
      RUN:     step_c = (i_q <= n_q);
      FIN:     fin_c  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt     <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      err     <= 1'b0;
      j_out   <= '0;
      i_out   <= '0;
      inv_ok  <= 1'b0;
      n_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      id_q    <= 1'b0;
    end else begin
      gnt  <= 2'b00;
      done <= 1'b0;
      err  <= 1'b0;
      if (accept_c || reject_c) begin
        gnt <= arb_gnt_c;
        err <= reject_c;
      end
      if (accept_c) begin
        n_q  <= sel_n_c;
        k_q  <= sel_k_c;
        i_q  <= '0;
        j_q  <= '0;
        id_q <= arb_id_c;
        busy <= 1'b1;
      end
      if (step_c) begin
        i_q <= i_q + W'(1);
        j_q <= j_q + i_q;
      end
      if (fin_c) begin
        j_out   <= j_q;
        i_out   <= i_q;
        done_id <= id_q;
        inv_ok  <= inv_check(n_q, k_q, j_q, i_q);
        done    <= 1'b1;
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sum_loop_sched.sv
// Scoreboard bench for sum_loop_sched: directed jobs, monitor checks grants and results.
module tb_sum_loop_sched;
  import sum_loop_pkg::*;

  localparam int unsigned W = SL_W;

  typedef struct {
    logic [1:0] gnt;
    logic       err;
  } gexp_t;

  typedef struct {
    int j;
    int i;
    int inv;
    int id;
    int lat;
  } rexp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] n_in0, k_in0, n_in1, k_in1;
  logic [1:0]   gnt;
  logic         busy, done, done_id, err, inv_ok;
  logic [W-1:0] j_out, i_out;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t gm;
  rexp_t rm;
  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int gnt_cyc = 0;

  sum_loop_sched #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .n_in0   (n_in0),
    .k_in0   (k_in0),
    .n_in1   (n_in1),
    .k_in1   (k_in1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .err     (err),
    .j_out   (j_out),
    .i_out   (i_out),
    .inv_ok  (inv_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_g(input logic [1:0] g, input logic e);
    gexp_t x;
    x.gnt = g;
    x.err = e;
    gq.push_back(x);
  endtask

  task automatic push_r(input int j, input int i, input int inv, input int id, input int lat);
    rexp_t x;
    x.j = j; x.i = i; x.inv = inv; x.id = id; x.lat = lat;
    rq.push_back(x);
  endtask

  task automatic wait_gnt();
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (gnt != 2'b00) return;
    end
    checks++;
    errors++;
    $display("FAIL gnt_timeout actual=none expected=grant");
  endtask

  task automatic wait_done();
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout actual=none expected=done");
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a result.
  always @(negedge clk) begin
    if (rst) begin
      if (gnt != 2'b00) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", int'(gnt), 0);
        end else begin
          gm = gq.pop_front();
          chk("gnt", int'(gnt), int'(gm.gnt));
          chk("err", int'(err), int'(gm.err));
          gnt_cyc = cyc;
        end
      end else if (err) begin
        chk("stray_err", int'(err), 0);
      end
      if (done) begin
        if (rq.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          rm = rq.pop_front();
          chk("j_out", int'(j_out), rm.j);
          chk("i_out", int'(i_out), rm.i);
          chk("inv_ok", int'(inv_ok), rm.inv);
          chk("done_id", int'(done_id), rm.id);
          chk("latency", cyc - gnt_cyc, rm.lat);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    req = 2'b00;
    n_in0 = '0; k_in0 = '0; n_in1 = '0; k_in1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_j_out", int'(j_out), 0);
    chk("rst_i_out", int'(i_out), 0);
    chk("rst_inv_ok", int'(inv_ok), 0);
    rst = 1'b1;

    // basic run, requester 0
    n_in0 = W'(100); k_in0 = W'(80);
    push_g(2'b01, 1'b0);
    push_r(5050, 101, 1, 0, 102);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    chk("busy_run", int'(busy), 1);
    wait_done();
    chk("busy_at_done", int'(busy), 0);

    // zero bound, requester 1
    n_in1 = W'(0); k_in1 = W'(0);
    push_g(2'b10, 1'b0);
    push_r(0, 1, 1, 1, 2);
    req = 2'b10;
    wait_gnt();
    req = 2'b00;
    wait_done();

    // held tie alternates 0,1,0
    n_in0 = W'(3); k_in0 = W'(0); n_in1 = W'(3); k_in1 = W'(0);
    push_g(2'b01, 1'b0); push_r(6, 4, 1, 0, 5);
    push_g(2'b10, 1'b0); push_r(6, 4, 1, 1, 5);
    push_g(2'b01, 1'b0); push_r(6, 4, 1, 0, 5);
    req = 2'b11;
    wait_gnt();
    wait_done();
    wait_gnt();
    wait_done();
    wait_gnt();
    req = 2'b00;
    wait_done();

    // rejection of an all-ones bound
    n_in0 = W'(8191);
    push_g(2'b01, 1'b1);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    chk("busy_reject", int'(busy), 0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("busy_after_reject", int'(busy), 0);
      chk("done_after_reject", int'(done), 0);
    end

    // next tie goes to requester 1
    n_in0 = W'(1); k_in0 = W'(0); n_in1 = W'(1); k_in1 = W'(0);
    push_g(2'b10, 1'b0);
    push_r(1, 2, 1, 1, 3);
    req = 2'b11;
    wait_gnt();
    req = 2'b00;
    wait_done();

    // wrap-around: 20100 mod 8192
    n_in0 = W'(200); k_in0 = W'(0);
    push_g(2'b01, 1'b0);
    push_r(3716, 201, 1, 0, 202);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    wait_done();

    // invariant boundary: j=64, i=129, 2n=256 vs k+193
    n_in0 = W'(128); k_in0 = W'(63);
    push_g(2'b01, 1'b0);
    push_r(64, 129, 0, 0, 130);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    wait_done();

    k_in0 = W'(64);
    push_g(2'b01, 1'b0);
    push_r(64, 129, 1, 0, 130);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    wait_done();

    // reset mid-run drops the job
    n_in0 = W'(100); k_in0 = W'(0);
    push_g(2'b01, 1'b0);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    repeat (50) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_j_out", int'(j_out), 0);
    chk("midrst_i_out", int'(i_out), 0);
    chk("midrst_inv_ok", int'(inv_ok), 0);
    rst = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("midrst_no_done", int'(done), 0);
    end

    // first tie after reset goes to requester 0
    n_in0 = W'(2); k_in0 = W'(0); n_in1 = W'(2); k_in1 = W'(0);
    push_g(2'b01, 1'b0);
    push_r(3, 3, 1, 0, 4);
    req = 2'b11;
    wait_gnt();
    req = 2'b00;
    wait_done();

    repeat (3) @(negedge clk);
    chk("gnt_queue_drained", gq.size(), 0);
    chk("result_queue_drained", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
